// File: rtl/rstseq_pkg.sv
// Shared types and helpers for the reset sequencer.
// Optional feature: define RSTSEQ_SYNC_EN for 2-flop input synchronisers.
package rstseq_pkg;

    // Sequencer phases: hold all domains, release one by one, all released.
    typedef enum logic [1:0] {
        ASSERT,
        RELEASE,
        RUN
    } rstseq_state_e;

    // Bit width needed for a counter holding 0..max_val.
    // Sizes the stretch counter (STRETCH), the wait counter (TIMEOUT-1),
    // the domain index and the filter counters.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rstseq_filter.sv
// Per-source request conditioning: optional 2-flop synchroniser followed by
// a FILTER-deep saturating counter. acc is high while the counter is full
// and the source is not masked.
// Optional feature: RSTSEQ_SYNC_EN adds the synchroniser.
module rstseq_filter
    import rstseq_pkg::*;
#(
    parameter int FILTER = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic mask,
    output logic acc
);

    localparam int CNT_W = cnt_w(FILTER);

    logic             req_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef RSTSEQ_SYNC_EN
    logic [1:0] sync_q, sync_d;

    // Shift the raw request through two flops before anything looks at it.
    always_comb begin
        sync_d = {sync_q[0], req};
    end

    // Synchroniser flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign req_s = sync_q[1];
`else
    assign req_s = req;
`endif

    // Count consecutive high samples, saturating at FILTER; any low sample restarts.
    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (!req_s) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(FILTER)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Filter counter register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all flop updates so every register samples pre-edge values.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign acc = (cnt_q == CNT_W'(FILTER)) && !mask;

endmodule

// File: rtl/reset_sequencer.sv
// Reset manager: accepts NUM_SRC filtered reset requests, stretches the
// reset, then releases NUM_DOM domains in order with a ready handshake and
// timeout. Keeps sticky cause and timeout flags for software.
// Optional feature: RSTSEQ_SYNC_EN synchronises src_req and dom_ready.
module reset_sequencer
    import rstseq_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int NUM_DOM = 3,
    parameter int FILTER  = 2,
    parameter int STRETCH = 16,
    parameter int STAGGER = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic [NUM_SRC-1:0] src_mask,
    input  logic [NUM_DOM-1:0] dom_ready,
    input  logic               cause_clr,
    output logic [NUM_DOM-1:0] dom_rst,
    output logic               seq_busy,
    output logic [NUM_SRC:0]   cause,
    output logic [NUM_DOM-1:0] tmo_err
);

    localparam int STRETCH_W = cnt_w(STRETCH);
    localparam int WAIT_W    = cnt_w(TIMEOUT - 1);
    localparam int IDX_W     = cnt_w(NUM_DOM - 1);

    logic [NUM_SRC-1:0] acc, acc_rise;
    logic [NUM_DOM-1:0] ready_s;
    logic               advance;

    rstseq_state_e      state_q, state_d;
    logic [STRETCH_W-1:0] stretch_q, stretch_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_SRC-1:0] acc_q, acc_d;
    logic [NUM_DOM-1:0] dom_rst_q, dom_rst_d;
    logic               seq_busy_q, seq_busy_d;
    logic [NUM_SRC:0]   cause_q, cause_d;
    logic [NUM_DOM-1:0] tmo_q, tmo_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        rstseq_filter #(.FILTER(FILTER)) u_filter (
            .clk  (clk),
            .rst  (rst),
            .req  (src_req[i]),
            .mask (src_mask[i]),
            .acc  (acc[i])
        );
    end

`ifdef RSTSEQ_SYNC_EN
    logic [NUM_DOM-1:0] ready_meta_q, ready_meta_d, ready_sync_q, ready_sync_d;

    // Two-stage shift of the ready handshakes coming from other clock domains.
    always_comb begin
        ready_meta_d = dom_ready;
        ready_sync_d = ready_meta_q;
    end

    // Ready synchroniser flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_meta_q <= '0;
            ready_sync_q <= '0;
        end else begin
            ready_meta_q <= ready_meta_d;
            ready_sync_q <= ready_sync_d;
        end
    end

    assign ready_s = ready_sync_q;
`else
    assign ready_s = dom_ready;
`endif

    // Next-state, counters, sticky flags and registered output values.
    always_comb begin
        state_d   = state_q;
        stretch_d = stretch_q;
        wait_d    = wait_q;
        idx_d     = idx_q;
        acc_d     = acc;
        cause_d   = cause_q;
        tmo_d     = tmo_q;
        advance   = 1'b0;
        acc_rise  = acc & ~acc_q;

        // Clear first so a cause or timeout arriving in the same cycle wins.
        if (cause_clr) begin
            cause_d = '0;
            tmo_d   = '0;
        end
        cause_d[NUM_SRC-1:0] = cause_d[NUM_SRC-1:0] | acc_rise;

        if (|acc) begin
            // Any accepted request restarts the whole sequence from scratch.
            state_d   = ASSERT;
            stretch_d = STRETCH_W'(STRETCH);
            idx_d     = '0;
            wait_d    = '0;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (stretch_q <= STRETCH_W'(1)) begin
                        state_d = RELEASE;
                        idx_d   = '0;
                        wait_d  = '0;
                    end else begin
                        stretch_d = stretch_q - STRETCH_W'(1);
                    end
                end
                RELEASE: begin
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_q >= WAIT_W'(STAGGER - 1) && ready_s[idx_q]) begin
                        advance = 1'b1;
                    end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                        advance     = 1'b1;
                        tmo_d[idx_q] = 1'b1;
                    end
                    if (advance) begin
                        if (idx_q == IDX_W'(NUM_DOM - 1)) begin
                            state_d = RUN;
                        end else begin
                            idx_d  = idx_q + IDX_W'(1);
                            wait_d = '0;
                        end
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = ASSERT;
                end
            endcase
        end

        // Domains up to and including the current index are out of reset.
        dom_rst_d = '1;
        for (int d = 0; d < NUM_DOM; d++) begin
            case (state_d)
                RELEASE: dom_rst_d[d] = (d > int'(idx_d));
                RUN:     dom_rst_d[d] = 1'b0;
                default: dom_rst_d[d] = 1'b1;
            endcase
        end
        seq_busy_d = |dom_rst_d;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ASSERT;
            stretch_q  <= STRETCH_W'(STRETCH);
            wait_q     <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            dom_rst_q  <= '1;
            seq_busy_q <= 1'b1;
            cause_q    <= {1'b1, {NUM_SRC{1'b0}}};
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            stretch_q  <= stretch_d;
            wait_q     <= wait_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            dom_rst_q  <= dom_rst_d;
            seq_busy_q <= seq_busy_d;
            cause_q    <= cause_d;
            tmo_q      <= tmo_d;
        end
    end

    assign dom_rst  = dom_rst_q;
    assign seq_busy = seq_busy_q;
    assign cause    = cause_q;
    assign tmo_err  = tmo_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer. The stimulus process drives inputs
// once per cycle, advances a timestamp-based reference model and queues the
// expected outputs; the monitor pops one entry per clock and compares.
module tb_reset_sequencer;

    localparam int NUM_SRC = 4;
    localparam int NUM_DOM = 3;
    localparam int FILTER  = 2;
    localparam int STRETCH = 16;
    localparam int STAGGER = 4;
    localparam int TIMEOUT = 64;
`ifdef RSTSEQ_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic               clk;
    logic               rst;
    logic [NUM_SRC-1:0] src_req;
    logic [NUM_SRC-1:0] src_mask;
    logic [NUM_DOM-1:0] dom_ready;
    logic               cause_clr;
    logic [NUM_DOM-1:0] dom_rst;
    logic               seq_busy;
    logic [NUM_SRC:0]   cause;
    logic [NUM_DOM-1:0] tmo_err;

    reset_sequencer #(
        .NUM_SRC (NUM_SRC),
        .NUM_DOM (NUM_DOM),
        .FILTER  (FILTER),
        .STRETCH (STRETCH),
        .STAGGER (STAGGER),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_req   (src_req),
        .src_mask  (src_mask),
        .dom_ready (dom_ready),
        .cause_clr (cause_clr),
        .dom_rst   (dom_rst),
        .seq_busy  (seq_busy),
        .cause     (cause),
        .tmo_err   (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_DOM-1:0] dom_rst;
        logic               seq_busy;
        logic [NUM_SRC:0]   cause;
        logic [NUM_DOM-1:0] tmo;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model: each domain's release is a timestamp (edge number).
    int                 m_t = 0;
    int                 m_cnt[NUM_SRC];
    logic [NUM_SRC-1:0] m_acc_prev;
    logic [NUM_SRC:0]   m_cause;
    logic [NUM_DOM-1:0] m_tmo;
    int                 m_nrel;          // number of domains out of reset
    int                 m_rel[NUM_DOM];  // edge at which each domain was released
    int                 m_rel0_time;     // edge at which domain 0 is due
    bit                 m_done;
    logic [NUM_SRC-1:0] req_h1, req_h2;
    logic [NUM_DOM-1:0] rdy_h1, rdy_h2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Advance the model across the next rising edge using the driven inputs.
    task automatic model_edge();
        logic [NUM_SRC-1:0] req_eff;
        logic [NUM_SRC-1:0] acc;
        logic [NUM_DOM-1:0] rdy_eff;
        int  k;
        int  dt;
        bit  adv;
        if (S == 0) begin
            req_eff = src_req;
            rdy_eff = dom_ready;
        end else begin
            req_eff = req_h2;
            rdy_eff = rdy_h2;
        end
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) m_cnt[i] = 0;
            m_acc_prev  = '0;
            m_cause     = {1'b1, {NUM_SRC{1'b0}}};
            m_tmo       = '0;
            m_nrel      = 0;
            m_done      = 1'b0;
            m_rel0_time = m_t + STRETCH;
            req_h1 = '0; req_h2 = '0; rdy_h1 = '0; rdy_h2 = '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) acc[i] = (m_cnt[i] == FILTER) && !src_mask[i];
            if (cause_clr) begin
                m_cause = '0;
                m_tmo   = '0;
            end
            m_cause[NUM_SRC-1:0] = m_cause[NUM_SRC-1:0] | (acc & ~m_acc_prev);
            if (|acc) begin
                m_nrel      = 0;
                m_done      = 1'b0;
                m_rel0_time = m_t + STRETCH;
            end else if (m_nrel == 0) begin
                if (m_t == m_rel0_time) begin
                    m_rel[0] = m_t;
                    m_nrel   = 1;
                end
            end else if (!m_done) begin
                k   = m_nrel - 1;
                dt  = m_t - m_rel[k];
                adv = 1'b0;
                if (dt >= STAGGER && rdy_eff[k]) adv = 1'b1;
                else if (dt == TIMEOUT) begin
                    adv      = 1'b1;
                    m_tmo[k] = 1'b1;
                end
                if (adv) begin
                    if (m_nrel < NUM_DOM) begin
                        m_rel[m_nrel] = m_t;
                        m_nrel++;
                    end else begin
                        m_done = 1'b1;
                    end
                end
            end
            for (int i = 0; i < NUM_SRC; i++)
                m_cnt[i] = req_eff[i] ? ((m_cnt[i] < FILTER) ? m_cnt[i] + 1 : FILTER) : 0;
            m_acc_prev = acc;
            req_h2 = req_h1; req_h1 = src_req;
            rdy_h2 = rdy_h1; rdy_h1 = dom_ready;
        end
        m_t++;
    endtask

    // One clock: model the coming edge, queue its expectation, move to the next negedge.
    task automatic tick();
        exp_t e;
        model_edge();
        for (int d = 0; d < NUM_DOM; d++) e.dom_rst[d] = (d >= m_nrel);
        e.seq_busy = (m_nrel < NUM_DOM);
        e.cause    = m_cause;
        e.tmo      = m_tmo;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (!m_done && i < budget) begin
            tick();
            i++;
        end
    endtask

    task automatic pulse_req(input int src, input int len);
        src_req[src] = 1'b1;
        run(len);
        src_req[src] = 1'b0;
    endtask

    // Monitor: outputs are presented every clock; compare just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dom_rst",  32'(dom_rst),  32'(e.dom_rst));
                check("seq_busy", 32'(seq_busy), 32'(e.seq_busy));
                check("cause",    32'(cause),    32'(e.cause));
                check("tmo_err",  32'(tmo_err),  32'(e.tmo));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int burst[NUM_SRC];
        int mode[NUM_DOM];
        int i;

        rst = 1'b1; src_req = '0; src_mask = '0; dom_ready = '1; cause_clr = 1'b0;

        // Power-on: 3 reset cycles, ready tied high, full sequence.
        run(3);
        rst = 1'b0;
        run(40);

        // Glitch filter: short pulse ignored, FILTER-long pulse accepted.
        pulse_req(1, 1);
        run(10);
        pulse_req(1, 2);
        wait_done(200);

        // Masked source never accepted.
        src_mask = 4'b0100;
        pulse_req(2, 10);
        run(5);
        src_mask = '0;

        // Domain 1 never reports ready: timeout, then clear the flag.
        dom_ready = 3'b101;
        pulse_req(3, 3);
        wait_done(300);
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
        run(3);
        dom_ready = '1;

        // Abort right after domain 0 is released.
        pulse_req(0, 3);
        i = 0;
        while (m_nrel == 0 && i < 100) begin
            tick();
            i++;
        end
        pulse_req(0, 3);
        wait_done(200);

        // cause_clr in the same cycle that acc[3] rises.
        src_req[3] = 1'b1;
        run(FILTER + S);
        cause_clr = 1'b1;
        tick();
        cause_clr  = 1'b0;
        src_req[3] = 1'b0;
        wait_done(200);

        // Randomised traffic: request bursts, masks, flaky ready, clears, resets.
        for (int s = 0; s < NUM_SRC; s++) burst[s] = 0;
        for (int d = 0; d < NUM_DOM; d++) mode[d] = 0;
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 1999) == 0);
            cause_clr = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 99) == 0)
                src_mask = ($urandom_range(0, 3) == 0) ? NUM_SRC'($urandom) : '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (burst[s] == 0 && $urandom_range(0, 299) == 0) burst[s] = $urandom_range(1, 5);
                src_req[s] = (burst[s] != 0);
                if (burst[s] != 0) burst[s]--;
            end
            for (int d = 0; d < NUM_DOM; d++) begin
                if ($urandom_range(0, 99) == 0) mode[d] = $urandom_range(0, 3);
                case (mode[d])
                    2:       dom_ready[d] = 1'($urandom_range(0, 1));
                    3:       dom_ready[d] = 1'b0;
                    default: dom_ready[d] = 1'b1;
                endcase
            end
            tick();
        end

        rst = 1'b0; src_req = '0; cause_clr = 1'b0; dom_ready = '1;
        run(10);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
